// File: rtl/serial_io_pkg.sv
// Shared widths, default FIFO geometry and the idle byte presented on empty heads.
package serial_io_pkg;

    localparam int SERIAL_W       = 8;
    localparam int DEFAULT_DEPTH  = 8;
    localparam int DEFAULT_ADDR_W = 3;

    localparam logic [SERIAL_W-1:0] SERIAL_IDLE_BYTE = 8'h00;

    // Occupancy encoding of a completely full FIFO, sized to the count port.
    function automatic logic [DEFAULT_ADDR_W:0] full_count_default();
        return (DEFAULT_ADDR_W + 1)'(DEFAULT_DEPTH);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO. The head byte is visible combinationally
// whenever the FIFO holds data; empty/full come from the registered count only.
module byte_fifo
    import serial_io_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [SERIAL_W-1:0] din,
    output logic [SERIAL_W-1:0] dout,
    output logic                empty,
    output logic                full,
    output logic [ADDR_W:0]     count
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [SERIAL_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // Illegal operations are dropped here so the count never leaves 0..DEPTH.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign dout = empty ? SERIAL_IDLE_BYTE : mem[rd_ptr];

    // Pointer and occupancy tracking; reset discards everything buffered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Byte storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/serial_io_bridge.sv
// Byte-stream bridge between the host link and the processor serial port.
// RX: host -> FIFO -> processor. TX: processor -> FIFO -> host.
// Every valid/ready seen by either side is derived from a FIFO's registered
// count, so no host input reaches a cpu output combinationally or vice versa.
module serial_io_bridge
    import serial_io_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic                clock,
    input  logic                reset,
    output logic [SERIAL_W-1:0] cpu_serial_in,
    output logic                cpu_valid,
    output logic                cpu_ready,
    input  logic [SERIAL_W-1:0] cpu_serial_out,
    input  logic                cpu_rden,
    input  logic                cpu_wren,
    input  logic [SERIAL_W-1:0] host_rx_data,
    input  logic                host_rx_valid,
    output logic                host_rx_ready,
    output logic [SERIAL_W-1:0] host_tx_data,
    output logic                host_tx_valid,
    input  logic                host_tx_ready,
    input  logic                status_clr,
    output logic [ADDR_W:0]     rx_count,
    output logic [ADDR_W:0]     tx_count,
    output logic                rx_underflow,
    output logic                tx_overflow
);

    logic rx_empty;
    logic rx_full;
    logic tx_empty;
    logic tx_full;
    logic rx_push;
    logic rx_pop;
    logic tx_push;
    logic tx_pop;

    assign cpu_valid     = !rx_empty;
    assign host_rx_ready = !rx_full;
    assign cpu_ready     = !tx_full;
    assign host_tx_valid = !tx_empty;

    assign rx_push = host_rx_valid && host_rx_ready;
    assign rx_pop  = cpu_rden && cpu_valid;
    assign tx_push = cpu_wren && cpu_ready;
    assign tx_pop  = host_tx_ready && host_tx_valid;

    byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (host_rx_data),
        .dout  (cpu_serial_in),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

    // A write while full is dropped rather than stalling the core.
    byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (cpu_serial_out),
        .dout  (host_tx_data),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    // Sticky error flags; a new error in the same cycle wins over status_clr.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_underflow <= 1'b0;
            tx_overflow  <= 1'b0;
        end else begin
            rx_underflow <= (cpu_rden && !cpu_valid) || (rx_underflow && !status_clr);
            tx_overflow  <= (cpu_wren && !cpu_ready) || (tx_overflow && !status_clr);
        end
    end

endmodule

// File: tb/tb_serial_io_bridge.sv
module tb_serial_io_bridge;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic             clock;
    logic             reset;
    logic [7:0]       cpu_serial_in;
    logic             cpu_valid;
    logic             cpu_ready;
    logic [7:0]       cpu_serial_out;
    logic             cpu_rden;
    logic             cpu_wren;
    logic [7:0]       host_rx_data;
    logic             host_rx_valid;
    logic             host_rx_ready;
    logic [7:0]       host_tx_data;
    logic             host_tx_valid;
    logic             host_tx_ready;
    logic             status_clr;
    logic [ADDR_W:0]  rx_count;
    logic [ADDR_W:0]  tx_count;
    logic             rx_underflow;
    logic             tx_overflow;

    serial_io_bridge #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .cpu_serial_in  (cpu_serial_in),
        .cpu_valid      (cpu_valid),
        .cpu_ready      (cpu_ready),
        .cpu_serial_out (cpu_serial_out),
        .cpu_rden       (cpu_rden),
        .cpu_wren       (cpu_wren),
        .host_rx_data   (host_rx_data),
        .host_rx_valid  (host_rx_valid),
        .host_rx_ready  (host_rx_ready),
        .host_tx_data   (host_tx_data),
        .host_tx_valid  (host_tx_valid),
        .host_tx_ready  (host_tx_ready),
        .status_clr     (status_clr),
        .rx_count       (rx_count),
        .tx_count       (tx_count),
        .rx_underflow   (rx_underflow),
        .tx_overflow    (tx_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: two byte queues plus two sticky bits.
    logic [7:0] rx_q [$];
    logic [7:0] tx_q [$];
    bit         m_und = 1'b0;
    bit         m_ovf = 1'b0;
    bit         model_ok = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT against model between edges, then advance the model
    // by what the coming rising edge must do.
    always @(negedge clock) begin
        int  rx_n;
        int  tx_n;
        bit  und_set;
        bit  ovf_set;
        logic [7:0] exp_b;
        rx_n = rx_q.size();
        tx_n = tx_q.size();
        if (model_ok) begin
            check("cpu_valid",     32'(cpu_valid),     32'(rx_n > 0));
            check("host_rx_ready", 32'(host_rx_ready), 32'(rx_n < DEPTH));
            check("cpu_serial_in", 32'(cpu_serial_in), (rx_n > 0) ? 32'(rx_q[0]) : 32'h0);
            check("rx_count",      32'(rx_count),      32'(rx_n));
            check("host_tx_valid", 32'(host_tx_valid), 32'(tx_n > 0));
            check("cpu_ready",     32'(cpu_ready),     32'(tx_n < DEPTH));
            check("host_tx_data",  32'(host_tx_data),  (tx_n > 0) ? 32'(tx_q[0]) : 32'h0);
            check("tx_count",      32'(tx_count),      32'(tx_n));
            check("rx_underflow",  32'(rx_underflow),  32'(m_und));
            check("tx_overflow",   32'(tx_overflow),   32'(m_ovf));
        end
        if (!reset) begin
            rx_q.delete();
            tx_q.delete();
            m_und    = 1'b0;
            m_ovf    = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            und_set = cpu_rden && (rx_n == 0);
            ovf_set = cpu_wren && (tx_n == DEPTH);
            if (cpu_rden && rx_n > 0) begin
                exp_b = rx_q.pop_front();
                check("rx_pop_data", 32'(cpu_serial_in), 32'(exp_b));
            end
            if (host_rx_valid && rx_n < DEPTH) rx_q.push_back(host_rx_data);
            if (host_tx_ready && tx_n > 0) begin
                exp_b = tx_q.pop_front();
                check("tx_pop_data", 32'(host_tx_data), 32'(exp_b));
            end
            if (cpu_wren && tx_n < DEPTH) tx_q.push_back(cpu_serial_out);
            m_und = und_set || (m_und && !status_clr);
            m_ovf = ovf_set || (m_ovf && !status_clr);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_rden = 0; cpu_wren = 0; host_rx_valid = 0; status_clr = 0;
    endtask

    initial begin
        reset = 0; cpu_serial_out = 0; cpu_rden = 0; cpu_wren = 0;
        host_rx_data = 0; host_rx_valid = 0; host_tx_ready = 0; status_clr = 0;

        // 1 reset held two cycles
        tick(); tick();
        reset = 1;
        tick();

        // 2 RX pass-through
        host_rx_valid = 1; host_rx_data = 8'hAA; tick();
        host_rx_data = 8'h55; tick();
        host_rx_valid = 0; tick();
        cpu_rden = 1; tick();
        cpu_rden = 0; tick();
        cpu_rden = 1; tick();
        cpu_rden = 0; tick();

        // 3 RX full, ninth byte held, then pop while full
        for (int i = 1; i <= 9; i++) begin
            host_rx_valid = 1; host_rx_data = 8'(i); tick();
        end
        cpu_rden = 1; tick();
        cpu_rden = 0; tick();
        host_rx_valid = 0; tick();
        cpu_rden = 1;
        for (int i = 0; i < 9; i++) tick();
        cpu_rden = 0; tick();

        // 4 TX overflow then drain
        host_tx_ready = 0;
        for (int i = 0; i < 9; i++) begin
            cpu_wren = 1; cpu_serial_out = 8'(8'h10 + i); tick();
        end
        cpu_wren = 0; tick();
        host_tx_ready = 1;
        for (int i = 0; i < 9; i++) tick();
        status_clr = 1; tick();
        status_clr = 0; tick();

        // 5 underflow, simultaneous push, clear vs new underflow
        cpu_rden = 1; tick();
        host_rx_valid = 1; host_rx_data = 8'h3C; tick();
        host_rx_valid = 0; cpu_rden = 0; tick();
        cpu_rden = 1; tick();
        status_clr = 1; tick();
        cpu_rden = 0; tick();
        status_clr = 0; tick();

        // 6 mid-stream reset
        host_tx_ready = 0;
        for (int i = 0; i < 3; i++) begin
            host_rx_valid = 1; host_rx_data = 8'(8'hA0 + i);
            cpu_wren = (i < 2); cpu_serial_out = 8'(8'hB0 + i);
            tick();
        end
        idle_inputs();
        reset = 0; tick();
        reset = 1; tick();
        host_rx_valid = 1; host_rx_data = 8'h77; tick();
        host_rx_valid = 0; tick(); tick();
        host_tx_ready = 1; cpu_rden = 1; tick(); cpu_rden = 0;

        // Randomized traffic with shifting bias to reach full and empty often
        for (int seg = 0; seg < 12; seg++) begin
            int p_rx, p_rd, p_wr, p_tr;
            p_rx = $urandom_range(5, 95);
            p_rd = $urandom_range(5, 95);
            p_wr = $urandom_range(5, 95);
            p_tr = $urandom_range(5, 95);
            for (int c = 0; c < 160; c++) begin
                host_rx_valid  = ($urandom_range(0, 99) < p_rx);
                host_rx_data   = 8'($urandom);
                cpu_rden       = ($urandom_range(0, 99) < p_rd);
                cpu_wren       = ($urandom_range(0, 99) < p_wr);
                cpu_serial_out = 8'($urandom);
                host_tx_ready  = ($urandom_range(0, 99) < p_tr);
                status_clr     = ($urandom_range(0, 15) == 0);
                reset          = ($urandom_range(0, 299) != 0);
                tick();
            end
        end
        reset = 1; idle_inputs(); host_tx_ready = 0;
        tick(); tick();

        if (n_cmp < 12) begin
            n_mis++;
            $display("FAIL compare_count: got %0d expected at least 12", n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
